// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit that owns the HI/LO pair.
// Handshake: the unit is idle while busy=0. A start seen while idle is
// accepted on that edge; busy stays high for the 33 cycles that follow. On
// the edge that writes HI/LO, busy falls and done pulses high for exactly one
// cycle. start, hi_we and lo_we are ignored while busy=1.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  counter;
    logic [1:0]  op_q;
    logic [31:0] a_q;     // original dividend, returned as HI on divide by zero
    logic [31:0] b_q;     // multiplicand / divisor magnitude
    logic [63:0] acc;     // product accumulator; low word is the quotient shifter on divide
    logic [31:0] rem;     // partial remainder
    logic        neg_q;   // negate product / quotient in FIX
    logic        neg_r;   // negate remainder in FIX
    logic        b_zero;  // divide by zero

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;

    // Operand magnitudes and one multiply or divide iteration step.
    always_comb begin
        signed_op = ~op[0];
        a_mag     = (signed_op && A[31]) ? (~A + 32'd1) : A;
        b_mag     = (signed_op && B[31]) ? (~B + 32'd1) : B;
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
        div_shift = {rem, acc[31]};
        div_ge    = (div_shift >= {1'b0, b_q});
    end

    // Control FSM, iteration datapath and the HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc     <= 64'd0;
            rem     <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= CALC;
                        counter <= 5'd0;
                        busy    <= 1'b1;
                        op_q    <= op;
                        a_q     <= A;
                        b_q     <= b_mag;
                        acc     <= {32'd0, a_mag};
                        rem     <= 32'd0;
                        neg_q   <= signed_op & (A[31] ^ B[31]);
                        neg_r   <= signed_op & A[31];
                        b_zero  <= op[1] & (B == 32'd0);
                    end else begin
                        if (hi_we) HI <= wdata;
                        if (lo_we) LO <= wdata;
                    end
                end
                CALC: begin
                    if (op_q[1]) begin
                        // Restoring division: shift in next dividend bit, subtract if it fits.
                        rem        <= div_ge ? (div_shift[31:0] - b_q) : div_shift[31:0];
                        acc[31:0]  <= {acc[30:0], div_ge};
                    end else begin
                        // Shift-add multiply: conditionally add, then shift right.
                        acc <= {mul_sum, acc[31:1]};
                    end
                    counter <= counter + 5'd1;
                    if (counter == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (b_zero) begin
                        HI <= a_q;
                        LO <= 32'hFFFF_FFFF;
                    end else if (op_q[1]) begin
                        HI <= neg_r ? (~rem + 32'd1) : rem;
                        LO <= neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
                    end else begin
                        {HI, LO} <= neg_q ? (~acc + 64'd1) : acc;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    counter <= 5'd0;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    counter <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed scenarios followed by randomized operations
// and MTHI/MTLO writes, all checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [1:0]  op_c;
    logic [31:0] a_c;
    logic [31:0] b_c;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        int          sq;
        int          sr;
        longint      sp;
        logic [63:0] r;
        sa = a;
        sb = b;
        case (o)
            2'd0: begin
                sp = longint'(sa) * longint'(sb);
                r  = sp;
            end
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0)                                   r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr, sq};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // driver: present an operation and let edge E accept it
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit with_mt);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        if (with_mt) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = $urandom;
        end
        op_c = o;
        a_c  = a;
        b_c  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 2'($urandom_range(0, 3));
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // driver: run edges E+1..E+33, optionally disturbing the unit mid-flight
    task automatic finish_op(input bit disturb);
        int          bad_busy;
        int          bad_hold;
        logic [63:0] exp;
        bad_busy = 0;
        bad_hold = 0;
        exp = ref_op(op_c, a_c, b_c);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            if (HI !== hi_m || LO !== lo_m) bad_hold++;
            if (disturb && k == 5) begin
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
                A     = $urandom;
                B     = $urandom;
                hi_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            if (disturb && k == 6) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
        end
        chk("busy_through_calc", 64'(bad_busy), 64'd0);
        chk("hilo_hold_in_calc", 64'(bad_hold), 64'd0);
        @(posedge clk);
        #1;
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        chk("done_pulse", {62'd0, busy, done}, 64'd1);
        chk("result", {HI, LO}, exp);
    endtask

    // driver: one idle cycle, checking done has dropped
    task automatic idle_step();
        @(posedge clk);
        #1;
        chk("done_low", {62'd0, busy, done}, 64'd0);
    endtask

    // driver: MTHI/MTLO write while idle
    task automatic mt_write(input bit hw, input bit lw, input logic [31:0] d);
        hi_we = hw;
        lo_we = lw;
        wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hw) hi_m = d;
        if (lw) lo_m = d;
        chk("mt_write", {HI, LO}, {hi_m, lo_m});
    endtask

    initial begin
        int done_seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        A     = 32'd0;
        B     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {HI, LO, 30'd0, busy, done}, 96'd0);
        rst = 1'b0;
        idle_step();

        // MULTU all-ones
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op(1'b0);
        idle_step();

        // MULT -3*7 then DIV -7/2
        start_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        finish_op(1'b0);
        idle_step();
        start_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        finish_op(1'b0);
        idle_step();

        // divide by zero and signed overflow
        start_op(2'd3, 32'd100, 32'd0, 1'b0);
        finish_op(1'b0);
        idle_step();
        start_op(2'd2, 32'hDEAD_0001, 32'd0, 1'b0);
        finish_op(1'b0);
        idle_step();
        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        finish_op(1'b0);

        // back-to-back: start in the done cycle
        start_op(2'd3, 32'd100, 32'd7, 1'b0);
        finish_op(1'b0);
        idle_step();

        // ignored start/hi_we while busy, then MTLO while idle
        start_op(2'd0, 32'h0001_2345, 32'hFFFF_0F0F, 1'b0);
        finish_op(1'b1);
        idle_step();
        mt_write(1'b0, 1'b1, 32'h1234_5678);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);

        // MT write in the same cycle as an accepted start is dropped
        start_op(2'd1, 32'd9, 32'd11, 1'b1);
        finish_op(1'b0);
        idle_step();

        // reset during CALC aborts the operation
        start_op(2'd1, 32'd5, 32'd6, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        chk("abort_state", {HI, LO, 30'd0, busy, done}, 96'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        chk("abort_hilo", {HI, LO}, {hi_m, lo_m});

        // randomized operations with occasional MT writes and back-to-back starts
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            start_op(ro, ra, rb, 1'b0);
            finish_op(1'b0);
            if ($urandom_range(0, 1) == 1) begin
                idle_step();
                if ($urandom_range(0, 1) == 1)
                    mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
        end
        idle_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that sits beside the main ALU in the MIPS execute stage and owns the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles with a busy/done handshake to the pipeline controller. It also services MTHI/MTLO writes. HI/LO are always readable for MFHI/MFLO.

## Interface
Parameters:
- none; data width fixed at 32 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when idle.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  input  32  multiplicand / dividend; captured on the accepting edge.
- B  input  32  multiplier / divisor; captured on the accepting edge.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  32  data for MTHI/MTLO.
- busy  output  1  operation in progress; pipeline stalls MF*/MT*/new mult-div while high.
- done  output  1  one-cycle pulse when the result has been written to HI/LO.
- HI  output  32  HI register (product high word / remainder).
- LO  output  32  LO register (product low word / quotient).

## Operation
- FSM states:
  - IDLE: on start=1, capture operands and op, go to CALC, counter=0, busy=1.
  - CALC: 32 iterations, one per cycle; counter 0..31. After the iteration with counter=31, go to FIX.
  - FIX: apply sign correction and write HI/LO; return to IDLE with done=1 for exactly one cycle.
- Signed ops iterate on magnitudes (two's-complement absolute value of A and B). Result signs are restored in FIX.
- Multiply: shift-add over 64-bit {HI,LO} accumulator. Unsigned result is the exact 64-bit product. Signed result is the negated 64-bit product when the operand signs differ.
- Divide: restoring division with a 33-bit partial remainder, one quotient bit per cycle.
  - LO = quotient truncated toward zero.
  - HI = remainder with the sign of the dividend.
  - Invariant: A = LO*B + HI.
- Divide by zero (both DIV and DIVU): completes with normal latency; LO=32'hFFFFFFFF, HI=A.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=32'h80000000, HI=0.
- MTHI/MTLO: when IDLE and start=0, hi_we/lo_we load wdata into HI/LO on the next edge. Both may be asserted together.
- Ignored inputs:
  - hi_we/lo_we while busy.
  - hi_we/lo_we in the same cycle as an accepted start (start wins).
  - start while busy; the in-flight operation is unaffected.
- HI/LO hold their previous values throughout CALC; they change only in FIX or on MT writes.

## Timing
- Reset values (next edge after rst=1): state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0.
- rst overrides everything, including mid-CALC or FIX: the operation is aborted and no result is written.
- Let E be the edge on which start is accepted.
  - busy=1 from after E through the edge E+33.
  - At edge E+33: HI/LO are written, busy goes 0 and done goes 1.
  - At edge E+34: done returns to 0.
  - Total latency: 33 cycles from acceptance to result.
- Back-to-back: start may be asserted in the cycle done=1 (state IDLE). It is accepted on edge E+34.
- Operand changes on A/B/op after E have no effect.
- busy and done are registered outputs with no combinational path from inputs.

## Test plan
- MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF -> after 33 cycles HI=32'hFFFFFFFE, LO=32'h00000001, done pulses once, busy high exactly 33 cycles.
- MULT A=-3, B=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. Then DIV A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU A=100, B=0 -> LO=32'hFFFFFFFF, HI=100. DIV A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- Start DIVU 100/7 in the cycle done=1 of a prior op -> accepted immediately, LO=14, HI=2, no idle gap.
- While busy: pulse start with new operands and assert hi_we with wdata=32'hDEADBEEF -> both ignored, original result delivered. When idle: lo_we with 32'h12345678 -> LO=32'h12345678 next cycle, HI unchanged.
- Assert rst on the 10th CALC cycle of MULTU 5*6 -> next edge busy=0, done=0, HI=LO=0; done never pulses for the aborted op.
